mcs4_loader_ctrl: RTL and testbench
===================================

Name: mcs4_loader_ctrl

Overview:
- Host-side controller that sequences the MCS-4 system between program-load and execution.
- Holds CPU, ROM and RAM in reset while streaming program bytes into the i4001 debug write port with auto-incrementing addresses.
- Releases system reset to run, either unlimited or for a bounded cycle budget, then re-halts.
- Sits between the PYNQ host interface and the mcs4 system top: drives the system rst and the dbg_addr/dbg_wdata/dbg_wen port.

Parameters:
- RUN_SHIFT, 8: run budget in clk cycles = cmd_arg << RUN_SHIFT.
- RUN_CNT_W, 12+RUN_SHIFT: width of the run-cycle down-counter.

Ports:
- clk  in  1  system clock (same clock as the mcs4 system).
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_op  in  2  mcs4::ctrl_op_t: SET_ADDR=0, LOAD=1, RUN=2, HALT=3.
- cmd_arg  in  12  operand; meaning depends on cmd_op.
- s_valid  in  1  load byte offered.
- s_ready  out  1  load byte accepted when s_valid && s_ready.
- s_data  in  8  program byte (mcs4::byte_t).
- sys_rst  out  1  reset to CPU/ROM/RAM; registered.
- dbg_addr  out  3x4  mcs4::char_t [2:0], ROM debug write address.
- dbg_wdata  out  8  mcs4::byte_t, ROM debug write data.
- dbg_wen  out  1  ROM debug write strobe, 1-cycle pulse.
- state  out  2  mcs4::ctrl_state_t: HALT=0, LOAD=1, RUN=2.
- err  out  1  sticky illegal-command flag.

Behaviour:
- Reset values:
  - state=HALT, sys_rst=1, dbg_wen=0, dbg_addr=0, dbg_wdata=0, err=0.
  - Address pointer=0, remaining=0, run counter=0.
- HALT (sys_rst=1, cmd_ready=1, s_ready=0):
  - SET_ADDR: pointer <= cmd_arg; stay in HALT.
  - LOAD: remaining <= cmd_arg, go to LOAD. If cmd_arg==0, set err and stay in HALT.
  - RUN: go to RUN. Counter <= cmd_arg<<RUN_SHIFT; cmd_arg==0 means unlimited.
  - HALT: clears err; stays in HALT.
- LOAD (sys_rst=1, cmd_ready=0, s_ready=1):
  - On each s handshake, the next cycle has dbg_wen=1, dbg_wdata=s_data, dbg_addr=pointer.
  - Pointer then increments and wraps 0xFFF -> 0x000. Remaining decrements.
  - Sustains one byte per cycle back-to-back.
  - The handshake with remaining==1 moves state to HALT in the same cycle the final dbg_wen pulses. s_ready drops on that next cycle.
- RUN (sys_rst=0 from the cycle after RUN is accepted, cmd_ready=1, s_ready=0):
  - A bounded run decrements the counter every cycle; on reaching 1 it goes to HALT. sys_rst is therefore low for exactly cmd_arg<<RUN_SHIFT cycles.
  - An unlimited run stays until HALT is accepted; sys_rst reasserts the next cycle.
  - SET_ADDR, LOAD or RUN accepted in RUN: ignored and err set.
  - HALT with a bounded run active: HALT wins.
  - Budget expiry in the same cycle as an accepted HALT command: result is HALT, err unchanged.
- dbg_wen is 0 in every state except the cycle after a LOAD handshake.
- dbg_addr/dbg_wdata hold their last value when idle.
- Pointer persists across RUN, so consecutive LOADs append.
- rst asserted mid-LOAD or mid-RUN: next cycle matches the reset values. No dbg_wen is issued for an in-flight byte.

Decomposition:
- mcs4 package gains ctrl_op_t and ctrl_state_t enums, plus localparam CTRL_ARG_W=12.
- No sub-module required. Datapath is pointer, remaining and run counters plus a 3-state FSM in one module.

Test Plan:
- Reset hold: rst high 3 cycles -> sys_rst=1, state=HALT, dbg_wen=0, cmd_ready=1, err=0.
- Back-to-back load: SET_ADDR 0x0FE, LOAD 4, bytes A1,B2,C3,D4 on 4 consecutive cycles -> dbg_wen on 4 consecutive cycles at addrs 0x0FE,0x0FF,0x100,0x101. State=HALT in the cycle of the last wen.
- Wrap and backpressure: SET_ADDR 0xFFF, LOAD 2, s_valid gapped -> writes at 0xFFF then 0x000; no wen during gaps.
- Bounded run: RUN arg 2 with RUN_SHIFT=8 -> sys_rst low for exactly 512 cycles, then state=HALT, sys_rst=1.
- Unlimited run and errors: RUN 0, then LOAD 3 -> err=1, state stays RUN. HALT -> sys_rst=1 next cycle. HALT again -> err=0. LOAD 0 in HALT -> err=1.
- Reset mid-load: LOAD 5, accept 2 bytes, pulse rst in the cycle of a third handshake -> no third dbg_wen, pointer=0, state=HALT.

Source files
------------

// File: rtl/mcs4_loader_ctrl_pkg.sv
// Shared types for the MCS-4 host loader controller: command opcodes,
// controller states and the nibble/byte data types of the MCS-4 system.
package mcs4_loader_ctrl_pkg;

  localparam int CTRL_ARG_W = 12;

  typedef logic [7:0] byte_t;
  typedef logic [3:0] char_t;

  typedef enum logic [1:0] {
    OP_SET_ADDR = 2'd0,
    OP_LOAD     = 2'd1,
    OP_RUN      = 2'd2,
    OP_HALT     = 2'd3
  } ctrl_op_t;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/mcs4_loader_ctrl.sv
// Host-side sequencer for the MCS-4 system. Holds CPU/ROM/RAM in reset
// while streaming program bytes into the ROM debug write port, then
// releases reset for an unlimited or cycle-bounded run.
module mcs4_loader_ctrl
  import mcs4_loader_ctrl_pkg::*;
#(
  parameter int RUN_SHIFT = 8,
  parameter int RUN_CNT_W = CTRL_ARG_W + RUN_SHIFT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  ctrl_op_t              cmd_op,
  input  logic [CTRL_ARG_W-1:0] cmd_arg,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  byte_t                 s_data,
  output logic                  sys_rst,
  output char_t [2:0]           dbg_addr,
  output byte_t                 dbg_wdata,
  output logic                  dbg_wen,
  output ctrl_state_t           state,
  output logic                  err
);

  logic [CTRL_ARG_W-1:0] ptr;
  logic [CTRL_ARG_W-1:0] remaining;
  logic [RUN_CNT_W-1:0]  run_cnt;
  logic [RUN_CNT_W-1:0]  run_budget;
  logic                  cmd_fire;
  logic                  s_fire;

  // Commands are refused only while a load burst is in progress; load
  // bytes are taken only during that burst.
  assign cmd_ready  = (state != ST_LOAD);
  assign s_ready    = (state == ST_LOAD);
  assign cmd_fire   = cmd_valid && cmd_ready;
  assign s_fire     = s_valid && s_ready;
  assign run_budget = RUN_CNT_W'(cmd_arg) << RUN_SHIFT;

  // Controller FSM plus pointer/remaining/run datapath; all outputs registered.
  // A run counter of 0 while in RUN marks an unlimited run, since a bounded
  // run leaves RUN as the counter hits 1 and never sits at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_HALT;
      sys_rst   <= 1'b1;
      dbg_wen   <= 1'b0;
      dbg_addr  <= '0;
      dbg_wdata <= '0;
      err       <= 1'b0;
      ptr       <= '0;
      remaining <= '0;
      run_cnt   <= '0;
    end else begin
      dbg_wen <= 1'b0;
      case (state)
        ST_HALT: begin
          if (cmd_fire) begin
            case (cmd_op)
              OP_SET_ADDR: ptr <= cmd_arg;
              OP_LOAD: begin
                if (cmd_arg == '0) begin
                  err <= 1'b1;
                end else begin
                  remaining <= cmd_arg;
                  state     <= ST_LOAD;
                end
              end
              OP_RUN: begin
                run_cnt <= run_budget;
                state   <= ST_RUN;
                sys_rst <= 1'b0;
              end
              OP_HALT: err <= 1'b0;
              default: ;
            endcase
          end
        end
        ST_LOAD: begin
          if (s_fire) begin
            dbg_wen   <= 1'b1;
            dbg_wdata <= s_data;
            dbg_addr  <= ptr;
            ptr       <= ptr + CTRL_ARG_W'(1);
            remaining <= remaining - CTRL_ARG_W'(1);
            if (remaining == CTRL_ARG_W'(1)) state <= ST_HALT;
          end
        end
        ST_RUN: begin
          // HALT wins over budget expiry and leaves err alone.
          if (cmd_fire && cmd_op == OP_HALT) begin
            state   <= ST_HALT;
            sys_rst <= 1'b1;
            run_cnt <= '0;
          end else begin
            if (cmd_fire) err <= 1'b1;
            if (run_cnt == RUN_CNT_W'(1)) begin
              state   <= ST_HALT;
              sys_rst <= 1'b1;
              run_cnt <= '0;
            end else if (run_cnt != '0) begin
              run_cnt <= run_cnt - RUN_CNT_W'(1);
            end
          end
        end
        default: begin
          state   <= ST_HALT;
          sys_rst <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcs4_loader_ctrl.sv
// Self-checking bench for mcs4_loader_ctrl: scoreboarded ROM debug writes,
// bounded/unlimited runs, error flag handling and reset mid-load.
module tb_mcs4_loader_ctrl;
  import mcs4_loader_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  ctrl_op_t    cmd_op;
  logic [11:0] cmd_arg;
  logic        s_valid;
  logic        s_ready;
  byte_t       s_data;
  logic        sys_rst;
  char_t [2:0] dbg_addr;
  byte_t       dbg_wdata;
  logic        dbg_wen;
  ctrl_state_t state;
  logic        err;

  typedef struct packed {
    logic [11:0] addr;
    byte_t       data;
  } wr_t;

  wr_t         sb[$];
  logic [11:0] ptr_m;
  int          checks;
  int          failures;

  mcs4_loader_ctrl #(.RUN_SHIFT(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .sys_rst(sys_rst), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_wen(dbg_wen),
    .state(state), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (dbg_wen === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_wen", 32'(dbg_addr), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_addr", 32'(dbg_addr), 32'(e.addr));
        chk("wr_data", 32'(dbg_wdata), 32'(e.data));
      end
    end
  end

  task automatic send_cmd(input ctrl_op_t op, input logic [11:0] arg);
    int t;
    t = 0;
    while (cmd_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("cmd_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic put_byte(input byte_t d);
    chk("s_ready", 32'(s_ready), 32'd1);
    s_valid = 1'b1;
    s_data  = d;
    sb.push_back({ptr_m, d});
    ptr_m = ptr_m + 12'd1;
    @(negedge clk);
    s_valid = 1'b0;
    chk("wen_pulse", 32'(dbg_wen), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int n;
    byte_t b2b[4];
    checks    = 0;
    failures  = 0;
    ptr_m     = 12'h000;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = OP_SET_ADDR;
    cmd_arg   = '0;
    s_valid   = 1'b0;
    s_data    = '0;

    // Reset hold
    repeat (3) @(negedge clk);
    chk("rst_sys_rst", 32'(sys_rst), 32'd1);
    chk("rst_state", 32'(state), 32'(ST_HALT));
    chk("rst_wen", 32'(dbg_wen), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_addr", 32'(dbg_addr), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back load across a 0x0FF->0x100 boundary
    send_cmd(OP_SET_ADDR, 12'h0FE);
    ptr_m = 12'h0FE;
    send_cmd(OP_LOAD, 12'd4);
    chk("load_state", 32'(state), 32'(ST_LOAD));
    chk("load_cmd_ready", 32'(cmd_ready), 32'd0);
    b2b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    for (int i = 0; i < 4; i++) put_byte(b2b[i]);
    chk("last_wen_state", 32'(state), 32'(ST_HALT));
    chk("last_s_ready", 32'(s_ready), 32'd0);
    @(negedge clk);
    chk("post_load_wen", 32'(dbg_wen), 32'd0);
    chk("hold_addr", 32'(dbg_addr), 32'h101);
    chk("hold_data", 32'(dbg_wdata), 32'hD4);

    // Address wrap with gapped source
    send_cmd(OP_SET_ADDR, 12'hFFF);
    ptr_m = 12'hFFF;
    send_cmd(OP_LOAD, 12'd2);
    put_byte(8'h11);
    repeat (3) begin
      @(negedge clk);
      chk("gap_wen", 32'(dbg_wen), 32'd0);
    end
    chk("gap_state", 32'(state), 32'(ST_LOAD));
    put_byte(8'h22);
    chk("wrap_state", 32'(state), 32'(ST_HALT));

    // Bounded run: 2 << 8 = 512 cycles of released reset
    send_cmd(OP_RUN, 12'd2);
    chk("run_state", 32'(state), 32'(ST_RUN));
    n = 0;
    while (sys_rst === 1'b0 && n < 2000) begin
      n++;
      @(negedge clk);
    end
    chk("run_len", 32'(n), 32'd512);
    chk("run_end_state", 32'(state), 32'(ST_HALT));
    chk("run_end_sys_rst", 32'(sys_rst), 32'd1);
    chk("run_end_err", 32'(err), 32'd0);

    // Unlimited run, illegal command, halt and error clear
    send_cmd(OP_RUN, 12'd0);
    repeat (20) @(negedge clk);
    chk("unl_sys_rst", 32'(sys_rst), 32'd0);
    chk("unl_state", 32'(state), 32'(ST_RUN));
    send_cmd(OP_LOAD, 12'd3);
    chk("ill_err", 32'(err), 32'd1);
    chk("ill_state", 32'(state), 32'(ST_RUN));
    chk("ill_sys_rst", 32'(sys_rst), 32'd0);
    send_cmd(OP_HALT, 12'd0);
    chk("halt_sys_rst", 32'(sys_rst), 32'd1);
    chk("halt_state", 32'(state), 32'(ST_HALT));
    chk("halt_err_kept", 32'(err), 32'd1);
    send_cmd(OP_HALT, 12'd0);
    chk("halt_clr_err", 32'(err), 32'd0);
    send_cmd(OP_LOAD, 12'd0);
    chk("load0_err", 32'(err), 32'd1);
    chk("load0_state", 32'(state), 32'(ST_HALT));
    send_cmd(OP_HALT, 12'd0);
    chk("err_clr2", 32'(err), 32'd0);

    // HALT cuts a bounded run short
    send_cmd(OP_RUN, 12'd1);
    repeat (10) @(negedge clk);
    send_cmd(OP_HALT, 12'd0);
    chk("early_halt_state", 32'(state), 32'(ST_HALT));
    chk("early_halt_sys_rst", 32'(sys_rst), 32'd1);
    chk("early_halt_err", 32'(err), 32'd0);

    // Pointer persisted across runs (0x001), then reset mid-load
    send_cmd(OP_LOAD, 12'd5);
    put_byte(8'h33);
    put_byte(8'h44);
    s_valid = 1'b1;
    s_data  = 8'h55;
    rst     = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    s_valid = 1'b0;
    chk("mid_rst_wen", 32'(dbg_wen), 32'd0);
    chk("mid_rst_state", 32'(state), 32'(ST_HALT));
    chk("mid_rst_sys_rst", 32'(sys_rst), 32'd1);
    chk("mid_rst_addr", 32'(dbg_addr), 32'd0);
    chk("mid_rst_data", 32'(dbg_wdata), 32'd0);
    @(negedge clk);
    chk("mid_rst_wen2", 32'(dbg_wen), 32'd0);
    ptr_m = 12'h000;
    send_cmd(OP_LOAD, 12'd1);
    put_byte(8'h5A);
    chk("ptr0_state", 32'(state), 32'(ST_HALT));
    @(negedge clk);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
